// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the retirement tracer.
// Entry fields are sized at the widest supported configuration; a narrower seq counter is zero-extended.
package cpu_trace_pkg;

    localparam int TR_XLEN      = 16;
    localparam int TR_INSTR_W   = 16;
    localparam int TR_REG_IDX_W = 3;
    localparam int TR_SEQ_W     = 16;
    localparam int OPC_W        = 4;
    localparam int NUM_OPC      = 16;
    localparam int STAT_W       = 32;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_OR   = 4'h2,
        OP_AND  = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_ROT  = 4'h7,
        OP_BNE  = 4'h8,
        OP_LDL  = 4'h9,
        OP_LDH  = 4'hA,
        OP_STL  = 4'hB,
        OP_STH  = 4'hC,
        OP_JMP  = 4'hD,
        OP_JAL  = 4'hE,
        OP_JR   = 4'hF
    } opcode_e;

    // JARL shares the JR encoding (link decided by wb_en); NOP is ADD into r0.
    localparam opcode_e OP_JARL = OP_JR;
    localparam opcode_e OP_NOP  = OP_ADD;

    typedef struct packed {
        logic [TR_SEQ_W-1:0]     seq;
        logic [TR_XLEN-1:0]      pc;
        logic [TR_INSTR_W-1:0]   instr;
        logic                    wb_en;
        logic [TR_REG_IDX_W-1:0] wb_idx;
        logic [TR_XLEN-1:0]      wb_data;
    } trace_entry_t;

    function automatic opcode_e opcode_of(input logic [TR_INSTR_W-1:0] instr);
        return opcode_e'(instr[TR_INSTR_W-1 -: OPC_W]);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with occupancy count; read data is the head entry, zero when empty.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push;
    logic             pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the empty gate below keeps stale words invisible.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/cpu_retire_tracer.sv
// Captures retired instructions, stamps a sequence number and queues them for the consumer.
// Optional per-opcode retire statistics are built when CPU_TRACE_STAT_EN is defined.
module cpu_retire_tracer
    import cpu_trace_pkg::*;
#(
    parameter int XLEN      = TR_XLEN,
    parameter int INSTR_W   = TR_INSTR_W,
    parameter int REG_IDX_W = TR_REG_IDX_W,
    parameter int DEPTH     = 8,
    parameter int SEQ_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ret_valid,
    output logic                    ret_ready,
    input  logic [XLEN-1:0]         ret_pc,
    input  logic [INSTR_W-1:0]      ret_instr,
    input  logic                    ret_wb_en,
    input  logic [REG_IDX_W-1:0]    ret_wb_idx,
    input  logic [XLEN-1:0]         ret_wb_data,
    output logic                    tr_valid,
    input  logic                    tr_ready,
    output trace_entry_t            tr_entry,
    output logic                    tr_overflow,
    output logic [$clog2(DEPTH):0]  tr_count
`ifdef CPU_TRACE_STAT_EN
    ,
    input  logic [OPC_W-1:0]        stat_sel,
    output logic [STAT_W-1:0]       stat_cnt
`endif
);

    localparam int EW = $bits(trace_entry_t);

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [SEQ_W-1:0] seq;
    trace_entry_t     wr_entry;
    logic [EW-1:0]    rd_vec;

    assign ret_ready = !full;
    assign tr_valid  = !empty;
    assign push      = ret_valid && !full;
    assign pop       = tr_valid && tr_ready;
    assign tr_entry  = trace_entry_t'(rd_vec);

    // Write-back fields are zeroed when unused so entries compare bit-for-bit.
    always_comb begin
        wr_entry              = '0;
        wr_entry.seq[SEQ_W-1:0] = seq;
        wr_entry.pc           = ret_pc;
        wr_entry.instr        = ret_instr;
        wr_entry.wb_en        = ret_wb_en;
        if (ret_wb_en) begin
            wr_entry.wb_idx  = ret_wb_idx;
            wr_entry.wb_data = ret_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq         <= '0;
            tr_overflow <= 1'b0;
        end else begin
            if (push)
                seq <= seq + 1'b1;
            if (ret_valid && full)
                tr_overflow <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_vec),
        .full    (full),
        .empty   (empty),
        .count   (tr_count)
    );

`ifdef CPU_TRACE_STAT_EN
    logic [STAT_W-1:0] stat_mem [NUM_OPC];
    logic [OPC_W-1:0]  op;

    assign op = ret_instr[INSTR_W-1 -: OPC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPC; i++)
                stat_mem[i] <= '0;
            stat_cnt <= '0;
        end else begin
            if (push && (stat_mem[op] != '1))
                stat_mem[op] <= stat_mem[op] + 1'b1;
            stat_cnt <= stat_mem[stat_sel];
        end
    end
`else
    // Statistics compiled out: no counters or read port exist in this build.
`endif

endmodule

// File: tb/tb_cpu_retire_tracer.sv
// Self-checking bench for cpu_retire_tracer: directed table, corner sequences and random traffic vs a queue model.
module tb_cpu_retire_tracer;
    import cpu_trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 4;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ret_valid = 1'b0;
    logic            ret_ready;
    logic [15:0]     ret_pc = '0;
    logic [15:0]     ret_instr = '0;
    logic            ret_wb_en = 1'b0;
    logic [2:0]      ret_wb_idx = '0;
    logic [15:0]     ret_wb_data = '0;
    logic            tr_valid;
    logic            tr_ready = 1'b0;
    trace_entry_t    tr_entry;
    logic            tr_overflow;
    logic [CW-1:0]   tr_count;
`ifdef CPU_TRACE_STAT_EN
    logic [3:0]      stat_sel = '0;
    logic [31:0]     stat_cnt;
`endif

    always #5 clk = ~clk;

    cpu_retire_tracer #(
        .DEPTH (DEPTH),
        .SEQ_W (SEQ_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ret_valid   (ret_valid),
        .ret_ready   (ret_ready),
        .ret_pc      (ret_pc),
        .ret_instr   (ret_instr),
        .ret_wb_en   (ret_wb_en),
        .ret_wb_idx  (ret_wb_idx),
        .ret_wb_data (ret_wb_data),
        .tr_valid    (tr_valid),
        .tr_ready    (tr_ready),
        .tr_entry    (tr_entry),
        .tr_overflow (tr_overflow),
        .tr_count    (tr_count)
`ifdef CPU_TRACE_STAT_EN
        ,
        .stat_sel    (stat_sel),
        .stat_cnt    (stat_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of expected entries plus sequence/overflow/statistics state.
    trace_entry_t mq[$];
    int           m_seq;
    bit           m_ovf;
    longint       m_stat[16];

    typedef struct {
        bit          rst;
        logic        rv;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        wbe;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        trdy;
        int          ecnt;
        logic        evalid;
        logic        erdy;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic trace_entry_t mk_entry(input logic [15:0] pc, input logic [15:0] instr,
                                              input logic wbe, input logic [2:0] idx,
                                              input logic [15:0] data, input int s);
        trace_entry_t e;
        e         = '0;
        e.seq     = 16'(s);
        e.pc      = pc;
        e.instr   = instr;
        e.wb_en   = wbe;
        e.wb_idx  = wbe ? idx : 3'd0;
        e.wb_data = wbe ? data : 16'd0;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_seq = 0;
        m_ovf = 0;
        for (int i = 0; i < 16; i++) m_stat[i] = 0;
    endtask

    task automatic do_reset();
        ret_valid = 1'b0;
        tr_ready  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Apply one cycle of inputs at a negedge, advance the model, and return at the next negedge.
    task automatic step(input logic rv, input logic [15:0] pc, input logic [15:0] instr,
                        input logic wbe, input logic [2:0] idx, input logic [15:0] data,
                        input logic trdy);
        bit was_full;
        ret_valid   = rv;
        ret_pc      = pc;
        ret_instr   = instr;
        ret_wb_en   = wbe;
        ret_wb_idx  = idx;
        ret_wb_data = data;
        tr_ready    = trdy;
        was_full = (mq.size() == DEPTH);
        if (trdy && mq.size() > 0)
            void'(mq.pop_front());
        if (rv && was_full)
            m_ovf = 1;
        else if (rv) begin
            mq.push_back(mk_entry(pc, instr, wbe, idx, data, m_seq));
            m_seq = (m_seq + 1) % (1 << SEQ_W);
            if (m_stat[instr[15:12]] < 64'hFFFF_FFFF)
                m_stat[instr[15:12]]++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},    tr_valid,    mq.size() != 0);
        chk({tag, ".count"},    tr_count,    mq.size());
        chk({tag, ".ready"},    ret_ready,   mq.size() < DEPTH);
        chk({tag, ".overflow"}, tr_overflow, m_ovf);
        if (mq.size() != 0)
            chk({tag, ".entry"}, tr_entry, mq[0]);
    endtask

    function automatic vec_t mkvec(input bit rst, input logic rv, input logic [15:0] pc,
                                   input logic [15:0] instr, input logic wbe, input logic [2:0] idx,
                                   input logic [15:0] data, input logic trdy, input int ecnt,
                                   input logic erdy, input logic eovf);
        vec_t v;
        v.rst = rst; v.rv = rv; v.pc = pc; v.instr = instr; v.wbe = wbe; v.idx = idx;
        v.data = data; v.trdy = trdy; v.ecnt = ecnt; v.evalid = (ecnt != 0);
        v.erdy = erdy; v.eovf = eovf;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Table: single retire then pop; fill with stalled consumer, overflow, pop at full, drain.
        tbl.push_back(mkvec(1, 1, 16'h0010, 16'h1234, 1, 3'd3, 16'hBEEF, 0, 1, 1, 0));
        tbl.push_back(mkvec(0, 0, 16'h0000, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 1, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mkvec(i == 0, 1, 16'(16'h0100 + i * 2), 16'(16'h2000 + i), 1,
                                3'(i), 16'(16'hA000 + i), 0, i + 1, i < 7, 0));
        tbl.push_back(mkvec(0, 1, 16'h0200, 16'h3000, 1, 3'd1, 16'h1111, 0, 8, 0, 1));
        tbl.push_back(mkvec(0, 1, 16'h0204, 16'h3001, 1, 3'd2, 16'h2222, 1, 7, 1, 1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mkvec(0, 0, 16'h0000, 16'h0000, 0, 3'd0, 16'h0000, 1, 6 - i, 1, 1));

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset.valid",    tr_valid,    1'b0);
        chk("reset.ready",    ret_ready,   1'b1);
        chk("reset.overflow", tr_overflow, 1'b0);
        chk("reset.count",    tr_count,    4'd0);
        chk("reset.entry",    tr_entry,    '0);

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rst) do_reset();
            step(tbl[r].rv, tbl[r].pc, tbl[r].instr, tbl[r].wbe, tbl[r].idx, tbl[r].data, tbl[r].trdy);
            chk($sformatf("tbl%0d.count", r),    tr_count,    tbl[r].ecnt);
            chk($sformatf("tbl%0d.valid", r),    tr_valid,    tbl[r].evalid);
            chk($sformatf("tbl%0d.ready", r),    ret_ready,   tbl[r].erdy);
            chk($sformatf("tbl%0d.overflow", r), tr_overflow, tbl[r].eovf);
            check_model($sformatf("tbl%0d", r));
            if (r == 0) begin
                chk("single.seq",     tr_entry.seq,     16'd0);
                chk("single.pc",      tr_entry.pc,      16'h0010);
                chk("single.instr",   tr_entry.instr,   16'h1234);
                chk("single.wb_en",   tr_entry.wb_en,   1'b1);
                chk("single.wb_idx",  tr_entry.wb_idx,  3'd3);
                chk("single.wb_data", tr_entry.wb_data, 16'hBEEF);
            end
            if (r >= 11)
                chk($sformatf("drain%0d.seq", r), tr_entry.seq, (r == 18) ? 16'd0 : 16'(r - 10));
        end

        // wb_en low masks write-back fields.
        do_reset();
        step(1, 16'h0040, 16'h5555, 0, 3'd5, 16'hFFFF, 0);
        chk("nowb.wb_idx",  tr_entry.wb_idx,  3'd0);
        chk("nowb.wb_data", tr_entry.wb_data, 16'd0);
        check_model("nowb");

        // Sustained push+pop at occupancy 3.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 16'(i), 16'(16'h1000 + i), 1, 3'(i), 16'(i * 7), 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 16'(16'h0300 + i), 16'($urandom), 1, 3'(i), 16'($urandom), 1);
            chk($sformatf("steady%0d.count", i), tr_count, 4'd3);
            check_model($sformatf("steady%0d", i));
        end

        // Sequence wrap: the 17th push carries seq 0 with a 4-bit counter.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            step(1, 16'(k), 16'h2000, 1, 3'd1, 16'(k), 1);
            check_model($sformatf("wrap%0d", k));
        end
        chk("wrap17.seq", tr_entry.seq, 16'd0);
        chk("wrap17.pc",  tr_entry.pc,  16'd17);

        // Asynchronous reset with entries queued.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 16'(16'h0500 + i), 16'h4000, 1, 3'd2, 16'(i), 0);
        chk("prereset.count", tr_count, 4'd5);
        ret_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.count", tr_count, 4'd0);
        chk("async_rst.valid", tr_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 16'h0600, 16'h4001, 1, 3'd4, 16'h00AA, 0);
        chk("postrst.seq", tr_entry.seq, 16'd0);
        check_model("postrst");

`ifdef CPU_TRACE_STAT_EN
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 16'(i), 16'h0001, 1, 3'd1, 16'd1, 1);
        for (int i = 0; i < 2; i++) step(1, 16'(i), 16'hD000, 0, 3'd0, 16'd0, 1);
        stat_sel = 4'd0;
        step(0, 16'd0, 16'd0, 0, 3'd0, 16'd0, 1);
        chk("stat.add", stat_cnt, 32'd3);
        stat_sel = 4'd13;
        step(0, 16'd0, 16'd0, 0, 3'd0, 16'd0, 1);
        chk("stat.jmp", stat_cnt, 32'd2);
        do_reset();
`endif

        // Random traffic: a slow consumer phase to hit full/overflow, then a fast one.
        for (int c = 0; c < 400; c++) begin
            logic rv;
            logic trdy;
            rv   = ($urandom_range(0, 3) != 0);
            trdy = (c < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            step(rv, 16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), trdy);
            check_model($sformatf("rand%0d", c));
        end

`ifdef CPU_TRACE_STAT_EN
        for (int s = 0; s < 16; s++) begin
            stat_sel = 4'(s);
            step(0, 16'd0, 16'd0, 0, 3'd0, 16'd0, 0);
            chk($sformatf("stat_rand%0d", s), stat_cnt, 32'(m_stat[s]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_retire_tracer.md
# cpu_retire_tracer

RTL-side producer of the retirement stream consumed by the C reference model. The block captures every instruction the CPU core retires, stamps it with a sequence number and buffers it in a FIFO. It presents the entries over a valid/ready port. The testbench scoreboard pops each entry, replays it through the model, and compares the register write-back.

## Interface
- XLEN, 16, data/PC width
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4]
- REG_IDX_W, 3, register index width
- DEPTH, 8, FIFO entries, power of two, at least 2
- SEQ_W, 16, sequence counter width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ret_valid  in  1  core retires an instruction this cycle
- ret_ready  out  1  tracer can accept; equals !full
- ret_pc  in  XLEN  PC of retired instruction
- ret_instr  in  INSTR_W  retired instruction word
- ret_wb_en  in  1  instruction wrote a register
- ret_wb_idx  in  REG_IDX_W  destination register
- ret_wb_data  in  XLEN  value written
- tr_valid  out  1  head entry available
- tr_ready  in  1  consumer takes head entry
- tr_entry  out  packed trace_entry_t  {seq, pc, instr, wb_en, wb_idx, wb_data}
- tr_overflow  out  1  sticky: ret_valid seen while ret_ready low
- tr_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Push when ret_valid && ret_ready. The entry stored is the inputs plus the current seq. seq increments by 1 per push and wraps modulo 2^SEQ_W.
- Pop when tr_valid && tr_ready. tr_entry shows the head entry; tr_entry is stable while tr_valid && !tr_ready.
- The core has no stall path. If ret_valid is high while the FIFO is full, the instruction is dropped, seq does not increment, and tr_overflow sets. tr_overflow clears only on reset.
- Full is count == DEPTH. ret_ready is 0 when full, even if a pop happens in the same cycle. No bypass through a full FIFO.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- When ret_wb_en = 0, the stored wb_idx and wb_data are forced to 0. The consumer can then compare entries bit-for-bit.
- Reset values: tr_valid 0, ret_ready 1 (deasserts while rst_n low is also acceptable, but it must read 1 in the first cycle after release), tr_overflow 0, tr_count 0, seq 0, tr_entry all zeros.
- Reset mid-operation discards all entries immediately and asynchronously.

## Timing
- Push-to-visible latency: an entry pushed at edge N drives tr_valid high after edge N; the consumer can pop it at edge N+1.
- tr_valid is a registered function of count (count != 0). There is no combinational path from ret_* to tr_*.
- ret_ready depends only on registered state. There is no combinational path from tr_ready to ret_ready.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- CPU_TRACE_STAT_EN defined: adds 16 per-opcode retire counters, each 32 bits, saturating at all-ones. Adds ports stat_sel (in, 4) and stat_cnt (out, 32). stat_cnt is a registered read of counter[stat_sel] with 1-cycle latency. Counters increment on accepted pushes only; dropped instructions are not counted. Counters reset to 0.
- CPU_TRACE_STAT_EN undefined: no counters, no stat ports, no related logic.

## Structure
- Package cpu_trace_pkg holds:
  - trace_entry_t (packed struct)
  - opcode_e: 4-bit enum ADD, ADDI, OR, AND, XOR, NOR, SLL, ROT, BNE, LDL, LDH, STL, STH, JMP, JAL, JR, plus the JARL/NOP encodings
  - the STAT_W = 32 constant
- Sub-module trace_fifo: a generic synchronous FIFO parameterized by WIDTH and DEPTH, exposing full, empty and count. cpu_retire_tracer instantiates it and owns seq, the overflow flag and the statistics.

## Test plan
- Single retire: pc=0x0010, instr=0x1234, wb_en=1, idx=3, data=0xBEEF -> tr_valid rises next cycle with seq=0 and all fields matching; pop -> tr_valid 0, count 0.
- Fill with consumer stalled (DEPTH=8): 8 pushes -> ret_ready 0, count 8, tr_overflow 0. A 9th ret_valid -> tr_overflow 1 and is dropped. Drain -> seq values 0..7 in order.
- Simultaneous push/pop at count 3 for 20 cycles -> count stays 3, tr_entry order and seq values continuous.
- wb_en=0 with idx=5, data=0xFFFF -> stored wb_idx=0 and wb_data=0.
- Seq wrap with SEQ_W=4: 17 pushes with continuous pops -> the 17th entry has seq 0.
- Reset asserted with count 5 -> count 0, tr_valid 0 immediately, seq restarts at 0. With CPU_TRACE_STAT_EN: 3 ADD + 2 JMP retires -> stat_cnt reads 3 and 2 one cycle after stat_sel is set.
